// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller: fetch/decode/exec/mem/writeback FSM
// sharing a single memory port, with illegal-opcode and memory-timeout traps.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_branch,
    output logic       reg_write,
    output logic [1:0] memtoreg,
    output logic       alusrc,
    output logic [2:0] aluop,
    output logic       mux_inp,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_FETCH_TO = 2'b10,
        CAUSE_MEM_TO   = 2'b11
    } cause_e;

    state_e            state_q, state_d;
    cause_e            cause_q, cause_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;

    logic              is_load, is_store, is_branch;
    logic [2:0]        dec_aluop;
    logic              dec_alusrc, dec_mux_inp;
    logic [1:0]        dec_wb_sel;
    logic              opcode_legal;
    logic              wait_expired;

    // Per-class datapath controls for the captured instruction
    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_branch   = 1'b0;
        dec_aluop   = 3'b000;
        dec_alusrc  = 1'b0;
        dec_mux_inp = 1'b0;
        dec_wb_sel  = WB_NONE;
        case (opcode_q)
            OP_R:      begin dec_aluop = 3'b000; dec_alusrc = 1'b0; dec_wb_sel = WB_ALU; end
            OP_I:      begin dec_aluop = 3'b001; dec_alusrc = 1'b1; dec_wb_sel = WB_ALU; end
            OP_LOAD:   begin dec_aluop = 3'b010; dec_alusrc = 1'b1; dec_wb_sel = WB_MEM; is_load = 1'b1; end
            OP_STORE:  begin dec_aluop = 3'b011; dec_alusrc = 1'b1; is_store = 1'b1; end
            OP_BRANCH: begin dec_aluop = 3'b100; dec_alusrc = 1'b0; is_branch = 1'b1; end
            OP_JAL:    begin dec_aluop = 3'b101; dec_alusrc = 1'b1; dec_wb_sel = WB_PC; end
            OP_JALR:   begin dec_aluop = 3'b001; dec_alusrc = 1'b1; dec_mux_inp = 1'b1; dec_wb_sel = WB_PC; end
            OP_LUI:    begin dec_aluop = 3'b110; dec_alusrc = 1'b1; dec_wb_sel = WB_PC; end
            OP_AUIPC:  begin dec_aluop = 3'b000; dec_alusrc = 1'b1; dec_wb_sel = WB_PC; end
            default:   ;
        endcase
    end

    // Legality of the live opcode, judged while in DECODE
    always_comb begin
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
            default:                           opcode_legal = 1'b0;
        endcase
    end

    assign wait_expired = (wcnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RST;
            cause_q  <= CAUSE_NONE;
            opcode_q <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            opcode_q <= opcode_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Next state and per-state outputs; the wait counter clears unless it is still waiting
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        opcode_d   = opcode_q;
        wcnt_d     = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_branch  = 1'b0;
        reg_write  = 1'b0;
        memtoreg   = WB_NONE;
        alusrc     = 1'b0;
        aluop      = 3'b000;
        mux_inp    = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_FETCH_TO;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end

            S_DECODE: begin
                opcode_d = opcode;
                if (opcode_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end

            S_EXEC: begin
                aluop   = dec_aluop;
                alusrc  = dec_alusrc;
                mux_inp = dec_mux_inp;
                if (is_branch) begin
                    pc_write   = 1'b1;
                    pc_branch  = branch_taken;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                aluop   = dec_aluop;
                alusrc  = dec_alusrc;
                mux_inp = dec_mux_inp;
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_MEM_TO;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end

            S_WB: begin
                aluop      = dec_aluop;
                alusrc     = dec_alusrc;
                mux_inp    = dec_mux_inp;
                memtoreg   = dec_wb_sel;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_TRAP: trap = 1'b1;

            default: state_d = S_RST;
        endcase
    end

    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencing controller for a multi-cycle build of the RV32I core.
- Replaces the single-cycle opcode decode with an FSM.
- Shares one unified memory port between instruction fetch and load/store.
- Drives per-state datapath enables, traps on illegal opcodes and memory timeouts.

Parameters:
TIMEOUT, 16, maximum cycles waiting for mem_ready in FETCH or MEM before trapping (legal range 2..255)
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  7  instruction[6:0] from the instruction register; sampled in DECODE only
mem_ready  in  1  memory completes the current request this cycle
branch_taken  in  1  branch comparator result; valid in EXEC
mem_req  out  1  memory request; held until mem_ready
mem_we  out  1  write strobe; valid while mem_req=1
ir_write  out  1  load the instruction register
pc_write  out  1  update the PC
pc_branch  out  1  PC select: branch target (1) or sequential/jump path (0)
reg_write  out  1  register file write enable
memtoreg  out  2  writeback select: 00 ALU, 01 memory, 10 PC/immediate path, 11 none
alusrc  out  1  ALU B operand: 0 register, 1 immediate
aluop  out  3  ALU operation class
mux_inp  out  1  ALU A operand: 1 selects rs1 for JALR target, 0 otherwise
instr_done  out  1  one-cycle pulse when an instruction retires
trap  out  1  sticky error flag
trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 memory-stage timeout
state  out  3  current state, for debug

Behaviour:
State encoding:
- RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.

Registers:
- state, opcode_q (7 bits), wait counter wcnt (CNT_W bits), trap_cause.
- All are cleared asynchronously by rst; state goes to RST.

Reset values:
- While rst is high and in RST, every output is 0, memtoreg=11 and state=0.
- The first rising edge after rst deasserts moves RST to FETCH.

Output timing:
- Outputs decode combinationally from state and opcode_q only.
- mem_ready and branch_taken gate pulses within the same cycle.

FETCH:
- mem_req=1, mem_we=0.
- On mem_ready: ir_write=1, go to DECODE, clear wcnt.

DECODE:
- Capture opcode into opcode_q.
- Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- Supported opcode: go to EXEC.
- Any other opcode: go to TRAP with cause 01.

EXEC (controls taken from opcode_q):
- R-type: aluop=000, alusrc=0.
- I-type: aluop=001, alusrc=1.
- Load: aluop=010, alusrc=1.
- Store: aluop=011, alusrc=1.
- Branch: aluop=100, alusrc=0.
- JAL: aluop=101, alusrc=1.
- JALR: aluop=001, alusrc=1, mux_inp=1.
- LUI: aluop=110, alusrc=1.
- AUIPC: aluop=000, alusrc=1.
- Branch: pc_write=1, pc_branch=branch_taken, instr_done=1, go to FETCH.
- Load and store: go to MEM.
- All others: go to WB.

MEM:
- ALU controls held as in EXEC; mem_req=1; mem_we=1 for store only.
- On mem_ready with store: pc_write=1, instr_done=1, go to FETCH.
- On mem_ready with load: go to WB.

WB:
- reg_write=1, pc_write=1, instr_done=1, go to FETCH.
- memtoreg: 00 for R/I-type, 01 for load, 10 for JAL/JALR/LUI/AUIPC.
- ALU controls held.

Wait timeout:
- wcnt increments each FETCH or MEM cycle without mem_ready.
- wcnt clears on any state change.
- If wcnt==TIMEOUT-1 and mem_ready=0: go to TRAP, cause 10 from FETCH or 11 from MEM.
- mem_ready in the timeout cycle wins; no trap is taken.

TRAP:
- Absorbing until rst; trap=1, trap_cause held.
- mem_req, pc_write, reg_write and ir_write are all 0.

Latency with zero-wait memory (mem_ready high on the first request cycle):
- Branch: 3 cycles.
- R/I/U-type, JAL, JALR, store: 4 cycles.
- Load: 5 cycles.
- Each memory wait cycle adds 1 cycle.

Invariants:
- pc_write fires exactly once per retired instruction.
- reg_write fires only in WB.
- mem_we=1 never occurs without mem_req=1.

Reset mid-operation:
- An asserted rst aborts immediately to RST.
- mem_req drops asynchronously and no partial write strobe persists.

Test Plan:
- Reset, then mem_ready=1 always, opcode=0110011 -> states 1,2,3,5,1; reg_write=1, memtoreg=00, aluop=000 in WB; instr_done pulse every 4 cycles.
- Load (0000011), mem_ready low for 3 MEM cycles -> mem_req=1, mem_we=0 held 4 cycles; then WB with memtoreg=01; retire after 8 cycles total.
- Store (0100011) -> mem_we=1 in MEM; reg_write never asserted; retire in MEM.
- Branch (1100011) with branch_taken=1, then with branch_taken=0 -> pc_branch=1 then 0 in EXEC; retire at 3 cycles; reg_write=0.
- opcode=1111111 -> TRAP after DECODE, trap_cause=01; outputs quiet for 20 cycles; rst clears trap.
- TIMEOUT=16, mem_ready held low in FETCH -> trap_cause=10 at the 16th FETCH cycle. Repeat with mem_ready=1 on cycle 16 -> no trap, DECODE entered.
- rst asserted mid-MEM on a store -> mem_req and mem_we drop without waiting for a clock edge; after release, FETCH is entered 1 cycle later.
